// File: rtl/mcyc_bus_checker.sv
// SM83 bus-cycle checker: walks the T-states of one traced instruction and
// records the first address, direction or write-data mismatch against a loaded table.
module mcyc_bus_checker #(
  parameter int DEPTH  = 6,
  parameter int ADR_T  = 2,
  parameter int DAT_T  = 3,
  parameter int W_ADR  = 16,
  parameter int W_DATA = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              tbl_we,
  input  logic [3:0]        tbl_idx,
  input  logic [W_ADR-1:0]  tbl_adr,
  input  logic              tbl_wr,
  input  logic              tbl_chk,
  input  logic [W_DATA-1:0] tbl_dat,
  input  logic [3:0]        len,
  input  logic              start,
  input  logic [W_ADR-1:0]  adr,
  input  logic              rd,
  input  logic              wr,
  input  logic [W_DATA-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic [3:0]        mcyc,
  output logic [2:0]        tcyc,
  output logic              err,
  output logic [3:0]        err_mcyc,
  output logic [1:0]        err_code
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);
  localparam logic [2:0] ADR_TC  = 3'(ADR_T);
  localparam logic [2:0] DAT_TC  = 3'(DAT_T);

  logic [1:0] state_reg;
  logic [3:0] len_reg;
  logic [3:0] eff_len;
  logic       tbl_ok;

  // Entry array spans the full 4-bit index so mcyc can address it directly;
  // slots outside 1..DEPTH read as permanently invalid.
  logic              ent_valid [16];
  logic [W_ADR-1:0]  ent_adr   [16];
  logic              ent_wr    [16];
  logic              ent_chk   [16];
  logic [W_DATA-1:0] ent_dat   [16];

  assign tbl_ok  = tbl_we && !busy && (tbl_idx != 4'd0) && (tbl_idx <= DEPTH_C);
  assign eff_len = ((len == 4'd0) || (len > DEPTH_C)) ? DEPTH_C : len;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_ent
      if ((gi >= 1) && (gi <= DEPTH)) begin : g_real
        logic              valid_reg;
        logic [W_ADR-1:0]  adr_reg;
        logic              wr_reg;
        logic              chk_reg;
        logic [W_DATA-1:0] dat_reg;

        always_ff @(posedge clk or negedge nreset) begin
          if (!nreset) begin
            valid_reg <= 1'b0;
          end else if (tbl_ok && (tbl_idx == 4'(gi))) begin
            valid_reg <= 1'b1;
          end
        end

        always_ff @(posedge clk) begin
          if (tbl_ok && (tbl_idx == 4'(gi))) begin
            adr_reg <= tbl_adr;
            wr_reg  <= tbl_wr;
            chk_reg <= tbl_chk;
            dat_reg <= tbl_dat;
          end
        end

        assign ent_valid[gi] = valid_reg;
        assign ent_adr[gi]   = adr_reg;
        assign ent_wr[gi]    = wr_reg;
        assign ent_chk[gi]   = chk_reg;
        assign ent_dat[gi]   = dat_reg;
      end else begin : g_none
        assign ent_valid[gi] = 1'b0;
        assign ent_adr[gi]   = '0;
        assign ent_wr[gi]    = 1'b0;
        assign ent_chk[gi]   = 1'b0;
        assign ent_dat[gi]   = '0;
      end
    end
  endgenerate

  logic       chk_adr;
  logic       chk_dat;
  logic       adr_bad;
  logic       dir_bad;
  logic       dat_bad;
  logic [1:0] hit_code;

  assign chk_adr = (state_reg == S_RUN) && (tcyc == ADR_TC) && ent_valid[mcyc];
  assign chk_dat = (state_reg == S_RUN) && (tcyc == DAT_TC) && ent_valid[mcyc];
  assign adr_bad = chk_adr && (adr != ent_adr[mcyc]);
  assign dir_bad = chk_adr && ((ent_wr[mcyc] && !wr) || (!ent_wr[mcyc] && !rd) || (rd && wr));
  assign dat_bad = chk_dat && ent_wr[mcyc] && ent_chk[mcyc] && (dout != ent_dat[mcyc]);

  always_comb begin
    hit_code = 2'd0;
    if (adr_bad) begin
      hit_code = 2'd1;
    end else if (dir_bad) begin
      hit_code = 2'd2;
    end else if (dat_bad) begin
      hit_code = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg <= S_IDLE;
      len_reg   <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mcyc      <= 4'd0;
      tcyc      <= 3'd0;
      err       <= 1'b0;
      err_mcyc  <= 4'd0;
      err_code  <= 2'd0;
    end else if (start) begin
      // A start in any state begins a fresh trace and forgets earlier errors.
      state_reg <= S_RUN;
      len_reg   <= eff_len;
      busy      <= 1'b1;
      done      <= 1'b0;
      mcyc      <= 4'd1;
      tcyc      <= 3'd1;
      err       <= 1'b0;
      err_mcyc  <= 4'd0;
      err_code  <= 2'd0;
    end else begin
      case (state_reg)
        S_RUN: begin
          if ((hit_code != 2'd0) && !err) begin
            err      <= 1'b1;
            err_mcyc <= mcyc;
            err_code <= hit_code;
          end
          if (tcyc == 3'd4) begin
            if (mcyc == len_reg) begin
              state_reg <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              mcyc      <= 4'd0;
              tcyc      <= 3'd0;
            end else begin
              mcyc <= mcyc + 4'd1;
              tcyc <= 3'd1;
            end
          end else begin
            tcyc <= tcyc + 3'd1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          done      <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcyc_bus_checker.sv
// Bench for mcyc_bus_checker: vector table of bus patterns with a scoreboard of
// expected trace outcomes, plus hand sequences for restart, table lock and reset.
module tb_mcyc_bus_checker;

  localparam int DEPTH = 6;
  localparam int ADR_T = 2;
  localparam int DAT_T = 3;

  logic        clk = 1'b0;
  logic        nreset;
  logic        tbl_we;
  logic [3:0]  tbl_idx;
  logic [15:0] tbl_adr;
  logic        tbl_wr;
  logic        tbl_chk;
  logic [7:0]  tbl_dat;
  logic [3:0]  len;
  logic        start;
  logic [15:0] adr;
  logic        rd;
  logic        wr;
  logic [7:0]  dout;
  logic        busy;
  logic        done;
  logic [3:0]  mcyc;
  logic [2:0]  tcyc;
  logic        err;
  logic [3:0]  err_mcyc;
  logic [1:0]  err_code;

  mcyc_bus_checker #(
    .DEPTH(DEPTH), .ADR_T(ADR_T), .DAT_T(DAT_T), .W_ADR(16), .W_DATA(8)
  ) dut (
    .clk(clk), .nreset(nreset),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_adr(tbl_adr), .tbl_wr(tbl_wr),
    .tbl_chk(tbl_chk), .tbl_dat(tbl_dat),
    .len(len), .start(start),
    .adr(adr), .rd(rd), .wr(wr), .dout(dout),
    .busy(busy), .done(done), .mcyc(mcyc), .tcyc(tcyc),
    .err(err), .err_mcyc(err_mcyc), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  len;
    int          bm;      // M-cycle whose bus is overridden, 0 = none
    logic [15:0] badr;
    logic        brd;
    logic        bwr;
    logic [7:0]  bdout;
    int          e_err;
    int          e_m;
    int          e_code;
  } vec_t;

  typedef struct {
    int err;
    int m;
    int code;
    int lat;
    int rise;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[13];
  int          checks = 0;
  int          failures = 0;

  logic [15:0] g_adr  [1:6];
  logic        g_rd   [1:6];
  logic        g_wr   [1:6];
  logic [7:0]  g_dout [1:6];
  int          ov_m;
  logic [15:0] ov_adr;
  logic        ov_rd;
  logic        ov_wr;
  logic [7:0]  ov_dout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic set_good();
    for (int m = 1; m <= 6; m++) begin
      g_adr[m] = 16'hFFFF; g_rd[m] = 1'b0; g_wr[m] = 1'b0; g_dout[m] = 8'h00;
    end
    g_adr[1] = 16'h0100; g_rd[1] = 1'b1;
    g_adr[2] = 16'hC000; g_wr[2] = 1'b1; g_dout[2] = 8'h5A;
    g_adr[3] = 16'h0300; g_rd[3] = 1'b1;
    ov_m = 0;
  endtask

  task automatic drive_bus(input int m);
    if (m >= 1 && m <= 6) begin
      if (m == ov_m) begin
        adr = ov_adr; rd = ov_rd; wr = ov_wr; dout = ov_dout;
      end else begin
        adr = g_adr[m]; rd = g_rd[m]; wr = g_wr[m]; dout = g_dout[m];
      end
    end else begin
      adr = 16'h0000; rd = 1'b0; wr = 1'b0; dout = 8'h00;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] idx, input logic [15:0] a, input logic w,
                      input logic c, input logic [7:0] d);
    tbl_we = 1'b1; tbl_idx = idx; tbl_adr = a; tbl_wr = w; tbl_chk = c; tbl_dat = d;
    step();
    tbl_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] l);
    len = l;
    start = 1'b1;
    step();
    start = 1'b0;
    tbl_we = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_mcyc"}, 32'(mcyc), 0);
    chk({tag, "_tcyc"}, 32'(tcyc), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_err_mcyc"}, 32'(err_mcyc), 0);
    chk({tag, "_err_code"}, 32'(err_code), 0);
  endtask

  // Called in the first RUN cycle; follows the trace to its done pulse.
  task automatic run_to_done(input bit lock);
    exp_t e;
    int   n;
    int   rise;
    bit   got;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sb.pop_front();
    n = 1; rise = 0; got = 1'b0;
    while (!got && n <= 200) begin
      if (err && rise == 0) rise = n;
      if (done) begin
        got = 1'b1;
      end else begin
        if (n < e.lat) begin
          chk("run_mcyc", 32'(mcyc), 32'((n - 1) / 4 + 1));
          chk("run_tcyc", 32'(tcyc), 32'((n - 1) % 4 + 1));
          chk("run_busy", 32'(busy), 1);
        end
        drive_bus((n - 1) / 4 + 1);
        if (lock && n == 2) begin
          tbl_we = 1'b1; tbl_idx = 4'd2; tbl_adr = 16'h1234;
          tbl_wr = 1'b0; tbl_chk = 1'b0; tbl_dat = 8'h00;
        end
        if (lock && n == 3) tbl_we = 1'b0;
        step();
        n++;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=%0d required=%0d", n, e.lat);
    end else begin
      $display("trace latency=%0d err=%0d err_mcyc=%0d err_code=%0d err_rise=%0d",
               n, err, err_mcyc, err_code, rise);
      chk("done_latency", 32'(n), 32'(e.lat));
      chk("busy_at_done", 32'(busy), 0);
      chk("err", 32'(err), 32'(e.err));
      chk("err_mcyc", 32'(err_mcyc), 32'(e.m));
      chk("err_code", 32'(err_code), 32'(e.code));
      chk("err_rise_cycle", 32'(rise), 32'(e.rise));
      drive_bus(0);
      step();
      chk("done_one_cycle", 32'(done), 0);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit lock);
    exp_t e;
    int   eff;
    ov_m = v.bm; ov_adr = v.badr; ov_rd = v.brd; ov_wr = v.bwr; ov_dout = v.bdout;
    eff = (v.len == 4'd0 || int'(v.len) > DEPTH) ? DEPTH : int'(v.len);
    e.err  = v.e_err;
    e.m    = v.e_err != 0 ? v.e_m : 0;
    e.code = v.e_err != 0 ? v.e_code : 0;
    e.lat  = 4 * eff + 1;
    e.rise = v.e_err != 0 ? 4 * (v.e_m - 1) + ((v.e_code == 3) ? DAT_T : ADR_T) + 1 : 0;
    sb.push_back(e);
    pulse_start(v.len);
    run_to_done(lock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    nreset = 1'b0; tbl_we = 1'b0; tbl_idx = 4'd0; tbl_adr = 16'h0; tbl_wr = 1'b0;
    tbl_chk = 1'b0; tbl_dat = 8'h0; len = 4'd0; start = 1'b0;
    adr = 16'h0; rd = 1'b0; wr = 1'b0; dout = 8'h0;
    set_good();
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    nreset = 1'b1;
    step();

    load(4'd1, 16'h0100, 1'b0, 1'b0, 8'h00);
    load(4'd2, 16'hC000, 1'b1, 1'b1, 8'h5A);

    //            len   bm  badr      brd   bwr   bdout  err m code
    vecs[0]  = '{4'd2,  0, 16'h0000, 1'b0, 1'b0, 8'h00, 0, 0, 0};
    vecs[1]  = '{4'd2,  2, 16'hC001, 1'b0, 1'b1, 8'h5A, 1, 2, 1};
    vecs[2]  = '{4'd2,  2, 16'hC000, 1'b0, 1'b1, 8'h5B, 1, 2, 3};
    vecs[3]  = '{4'd2,  2, 16'hC001, 1'b0, 1'b0, 8'h00, 1, 2, 1};
    vecs[4]  = '{4'd2,  2, 16'hC000, 1'b1, 1'b0, 8'h00, 1, 2, 2};
    vecs[5]  = '{4'd2,  1, 16'h0100, 1'b0, 1'b1, 8'h00, 1, 1, 2};
    vecs[6]  = '{4'd2,  1, 16'h0100, 1'b1, 1'b1, 8'h00, 1, 1, 2};
    vecs[7]  = '{4'd0,  0, 16'h0000, 1'b0, 1'b0, 8'h00, 0, 0, 0};
    vecs[8]  = '{4'd9,  0, 16'h0000, 1'b0, 1'b0, 8'h00, 0, 0, 0};
    vecs[9]  = '{4'd1,  1, 16'h0200, 1'b1, 1'b0, 8'h00, 1, 1, 1};
    vecs[10] = '{4'd1,  2, 16'h0000, 1'b0, 1'b0, 8'h00, 0, 0, 0};
    vecs[11] = '{4'd2,  1, 16'h0100, 1'b0, 1'b0, 8'h00, 1, 1, 2};
    vecs[12] = '{4'd15, 0, 16'h0000, 1'b0, 1'b0, 8'h00, 0, 0, 0};
    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], 1'b0);
    end

    // Table lock: a write to entry 2 while busy must be dropped.
    v = '{4'd2, 0, 16'h0000, 1'b0, 1'b0, 8'h00, 0, 0, 0};
    run_vec(v, 1'b1);
    run_vec(v, 1'b0);
    v = '{4'd2, 2, 16'hC000, 1'b0, 1'b1, 8'h5B, 1, 2, 3};
    run_vec(v, 1'b0);

    // start and tbl_we together while idle: entry 3 applies to this trace.
    tbl_we = 1'b1; tbl_idx = 4'd3; tbl_adr = 16'h0300; tbl_wr = 1'b0;
    tbl_chk = 1'b0; tbl_dat = 8'h00;
    v = '{4'd3, 3, 16'h0301, 1'b1, 1'b0, 8'h00, 1, 3, 1};
    run_vec(v, 1'b0);

    // Restart at mcyc=3 after an M1 address error.
    set_good();
    ov_m = 1; ov_adr = 16'h0101; ov_rd = 1'b1; ov_wr = 1'b0; ov_dout = 8'h00;
    pulse_start(4'd0);
    for (int n = 1; n <= 8; n++) begin
      drive_bus((n - 1) / 4 + 1);
      step();
    end
    chk("pre_restart_err", 32'(err), 1);
    chk("pre_restart_code", 32'(err_code), 1);
    chk("pre_restart_mcyc", 32'(mcyc), 3);
    ov_m = 0;
    sb.push_back('{0, 0, 0, 4 * DEPTH + 1, 0});
    drive_bus(3);
    pulse_start(4'd0);
    chk("restart_mcyc", 32'(mcyc), 1);
    chk("restart_tcyc", 32'(tcyc), 1);
    chk("restart_err", 32'(err), 0);
    chk("restart_err_code", 32'(err_code), 0);
    run_to_done(1'b0);

    // Reset in the middle of M2 T3, then an unloaded trace on a hostile bus.
    set_good();
    pulse_start(4'd2);
    for (int n = 1; n <= 6; n++) begin
      drive_bus((n - 1) / 4 + 1);
      step();
    end
    chk("pre_reset_mcyc", 32'(mcyc), 2);
    chk("pre_reset_tcyc", 32'(tcyc), 3);
    nreset = 1'b0;
    #1;
    check_zero_outputs("midreset");
    step();
    nreset = 1'b1;
    step();
    for (int m = 1; m <= 6; m++) begin
      g_adr[m] = 16'hAAAA; g_rd[m] = 1'b1; g_wr[m] = 1'b1; g_dout[m] = 8'hEE;
    end
    v = '{4'd2, 0, 16'h0000, 1'b0, 1'b0, 8'h00, 0, 0, 0};
    run_vec(v, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
